// File: rtl/rr_arb.sv
// rr_arb -- parametrised round-robin arbiter with registered one-hot grant.
//
// N request lines compete for one shared resource. A priority pointer marks
// the highest-priority requester; after every grant it moves to the slot just
// past the winner so that every active requester is served within N cycles.
// With HOLD=1 the current grantee keeps the grant while it keeps requesting.
//
// Parameters:
//   N    number of requesters (2..32)
//   HOLD 1 = grantee keeps the grant while its request stays high,
//        0 = grant rotates every arbitration cycle
//   IW   width of gnt_idx, derived as $clog2(N)
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst       synchronous active-high reset, dominates en and req
//   req       request vector, bit i = requester i wants the resource
//   en        arbitration enable, all state frozen while low
//   gnt       registered one-hot grant, all zeros = no grant
//   gnt_valid registered, high iff gnt is nonzero
//   gnt_idx   registered binary index of the granted bit, 0 when no grant

module rr_arb #(
   parameter  int N    = 8,
   parameter  int HOLD = 0,
   localparam int IW   = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic          gnt_valid,
   output logic [IW-1:0] gnt_idx
);

   // Highest legal index, held one bit wider than gnt_idx so that the
   // rotated search position (ptr + offset, up to 2N-2) never overflows.
   localparam logic [IW:0] LAST  = (IW+1)'(N - 1);
   localparam logic [IW:0] N_W   = (IW+1)'(N);

   logic [IW-1:0] ptr;

   logic          win_found;
   logic [IW-1:0] win_idx;
   logic [IW:0]   cand;
   logic [IW-1:0] ptr_nxt;
   logic [N-1:0]  gnt_nxt;
   logic          hold_keep;

   // Rotated find-first: walk offsets 0..N-1 from ptr, wrapping modulo N,
   // and take the first requesting slot. Depends only on req and ptr.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = {1'b0, ptr} + (IW+1)'(i);
         if (cand > LAST) begin
            cand = cand - N_W;
         end
         if (!win_found && req[cand[IW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IW-1:0];
         end
      end
   end

   // Pointer moves one past the winner; explicit wrap keeps non-power-of-two
   // N inside 0..N-1.
   always_comb begin
      ptr_nxt = (win_idx == LAST[IW-1:0]) ? '0 : win_idx + IW'(1);
      gnt_nxt = '0;
      gnt_nxt[win_idx] = 1'b1;
   end

   // Hold mode: keep the present grant untouched while its owner still asks.
   always_comb begin
      hold_keep = (HOLD != 0) && gnt_valid && req[gnt_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_idx   <= '0;
         ptr       <= '0;
      end else if (en) begin
         if (hold_keep) begin
            gnt       <= gnt;
            gnt_valid <= gnt_valid;
            gnt_idx   <= gnt_idx;
            ptr       <= ptr;
         end else if (win_found) begin
            gnt       <= gnt_nxt;
            gnt_valid <= 1'b1;
            gnt_idx   <= win_idx;
            ptr       <= ptr_nxt;
         end else begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
         end
      end
   end

   gnt_onehot_a : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
   gnt_valid_a  : assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt));

endmodule

// File: tb/tb_rr_arb.sv
// tb_rr_arb -- directed table, hold-mode sequence and multi-N reference sweep
// for the round-robin arbiter.

module tb_rr_arb;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- N=8, HOLD=0 ----------------
   logic       rst0, en0;
   logic [7:0] req0, g0;
   logic       v0;
   logic [2:0] x0;

   rr_arb #(.N(8), .HOLD(0)) u_rr (
      .clk(clk), .rst(rst0), .req(req0), .en(en0),
      .gnt(g0), .gnt_valid(v0), .gnt_idx(x0)
   );

   // ---------------- N=8, HOLD=1 ----------------
   logic       rst1, en1;
   logic [7:0] req1, g1;
   logic       v1;
   logic [2:0] x1;

   rr_arb #(.N(8), .HOLD(1)) u_hold (
      .clk(clk), .rst(rst1), .req(req1), .en(en1),
      .gnt(g1), .gnt_valid(v1), .gnt_idx(x1)
   );

   // ---------------- sweep instances ----------------
   logic        sw_rst, sw_en, sw_chk;
   logic [31:0] sw_req;

   function automatic int first_from(input logic [31:0] r, input int p, input int n);
      for (int k = 0; k < n; k++) begin
         if (r[(p + k) % n]) return (p + k) % n;
      end
      return -1;
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_sw
      localparam int NN  = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 5 : 16;
      localparam int IWW = $clog2(NN);

      logic [NN-1:0]  s_gnt;
      logic           s_v;
      logic [IWW-1:0] s_idx;

      rr_arb #(.N(NN), .HOLD(0)) u_sw (
         .clk(clk), .rst(sw_rst), .req(sw_req[NN-1:0]), .en(sw_en),
         .gnt(s_gnt), .gnt_valid(s_v), .gnt_idx(s_idx)
      );

      int          mptr    = 0;
      int          midx    = 0;
      logic        mv      = 1'b0;
      logic [31:0] mg      = '0;
      logic        edge_ok = 1'b0;
      logic [NN-1:0] preq  = '0;
      int          wt [NN];

      always @(posedge clk) begin
         if (sw_rst) begin
            mptr    <= 0;
            midx    <= 0;
            mv      <= 1'b0;
            mg      <= '0;
            edge_ok <= 1'b0;
         end else if (sw_en) begin
            edge_ok <= 1'b1;
            preq    <= sw_req[NN-1:0];
            if (sw_req[NN-1:0] == '0) begin
               mg   <= '0;
               mv   <= 1'b0;
               midx <= 0;
            end else begin
               midx <= first_from(sw_req, mptr, NN);
               mv   <= 1'b1;
               mg   <= 32'd1 << first_from(sw_req, mptr, NN);
               mptr <= (first_from(sw_req, mptr, NN) + 1) % NN;
            end
         end else begin
            edge_ok <= 1'b0;
         end
      end

      always @(negedge clk) begin
         if (sw_chk) begin
            chk($sformatf("n%0d_gnt", NN), 32'(s_gnt), mg);
            chk($sformatf("n%0d_vld", NN), 32'(s_v), 32'(mv));
            chk($sformatf("n%0d_idx", NN), 32'(s_idx), midx);
            chk($sformatf("n%0d_onehot", NN), 32'($onehot0(s_gnt)), 32'd1);
            chk($sformatf("n%0d_vld_or", NN), 32'(s_v), 32'(|s_gnt));
            chk($sformatf("n%0d_idx_gnt", NN),
                32'(s_v ? s_gnt[s_idx] : (s_idx == '0)), 32'd1);
            for (int i = 0; i < NN; i++) begin
               chk($sformatf("n%0d_wait%0d", NN, i),
                   32'(edge_ok && preq[i] && !s_gnt[i] && (wt[i] >= NN - 1)), 32'd0);
               if (edge_ok) begin
                  wt[i] <= (preq[i] && !s_gnt[i]) ? wt[i] + 1 : 0;
               end
            end
         end
      end
   end

   // ---------------- directed table ----------------
   typedef struct {
      logic       rst;
      logic       en;
      logic [7:0] req;
      logic [7:0] gnt;
      logic       vld;
      logic [2:0] idx;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic e, input logic [7:0] q,
                               input logic [7:0] gg, input logic v, input logic [2:0] x);
      vec_t t;
      t.rst = r; t.en = e; t.req = q; t.gnt = gg; t.vld = v; t.idx = x;
      return t;
   endfunction

   vec_t vecs[$];

   task automatic hstep(input logic r, input logic e, input logic [7:0] q,
                        input logic [7:0] gg, input logic [2:0] x, input string nm);
      rst1 = r; en1 = e; req1 = q;
      @(posedge clk); #1;
      chk({nm, "_gnt"}, 32'(g1), 32'(gg));
      chk({nm, "_vld"}, 32'(v1), 32'(gg != 8'h00));
      chk({nm, "_idx"}, 32'(x1), 32'(x));
   endtask

   initial begin
      rst0 = 1'b1; en0 = 1'b1; req0 = 8'h00;
      rst1 = 1'b1; en1 = 1'b1; req1 = 8'h00;
      sw_rst = 1'b1; sw_en = 1'b1; sw_req = '0; sw_chk = 1'b0;

      // rotation over 00101010
      vecs.push_back(mk(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0));
      vecs.push_back(mk(1'b0, 1'b1, 8'h2A, 8'h02, 1'b1, 3'd1));
      vecs.push_back(mk(1'b0, 1'b1, 8'h2A, 8'h08, 1'b1, 3'd3));
      vecs.push_back(mk(1'b0, 1'b1, 8'h2A, 8'h20, 1'b1, 3'd5));
      vecs.push_back(mk(1'b0, 1'b1, 8'h2A, 8'h02, 1'b1, 3'd1));
      vecs.push_back(mk(1'b0, 1'b1, 8'h2A, 8'h08, 1'b1, 3'd3));
      // idle keeps ptr=4
      vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0));
      vecs.push_back(mk(1'b0, 1'b1, 8'h2A, 8'h20, 1'b1, 3'd5));
      // freeze with changing req
      vecs.push_back(mk(1'b0, 1'b0, 8'hFF, 8'h20, 1'b1, 3'd5));
      vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h20, 1'b1, 3'd5));
      vecs.push_back(mk(1'b0, 1'b0, 8'h01, 8'h20, 1'b1, 3'd5));
      vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h40, 1'b1, 3'd6));
      vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h80, 1'b1, 3'd7));
      vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h01, 1'b1, 3'd0));
      // full load walk from reset
      vecs.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0));
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 8'(1 << i), 1'b1, 3'(i)));
      end
      vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h01, 1'b1, 3'd0));
      vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h02, 1'b1, 3'd1));
      vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h04, 1'b1, 3'd2));
      vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h08, 1'b1, 3'd3));
      vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h10, 1'b1, 3'd4));
      vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h20, 1'b1, 3'd5));
      // reset mid-grant, then restart from ptr=0
      vecs.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0));
      vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h01, 1'b1, 3'd0));
      // reset beats en=0, then frozen idle, then wrap from idx 7
      vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd0));
      vecs.push_back(mk(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd0));
      vecs.push_back(mk(1'b0, 1'b1, 8'h80, 8'h80, 1'b1, 3'd7));
      vecs.push_back(mk(1'b0, 1'b1, 8'h81, 8'h01, 1'b1, 3'd0));

      foreach (vecs[k]) begin
         rst0 = vecs[k].rst; en0 = vecs[k].en; req0 = vecs[k].req;
         @(posedge clk); #1;
         chk($sformatf("v%0d_gnt", k), 32'(g0), 32'(vecs[k].gnt));
         chk($sformatf("v%0d_vld", k), 32'(v0), 32'(vecs[k].vld));
         chk($sformatf("v%0d_idx", k), 32'(x0), 32'(vecs[k].idx));
      end

      // hold mode
      hstep(1'b1, 1'b1, 8'h00, 8'h00, 3'd0, "h_rst");
      hstep(1'b0, 1'b1, 8'h0A, 8'h02, 3'd1, "h_first");
      repeat (5) hstep(1'b0, 1'b1, 8'h0A, 8'h02, 3'd1, "h_hold");
      hstep(1'b0, 1'b1, 8'h08, 8'h08, 3'd3, "h_drop");
      repeat (2) hstep(1'b0, 1'b1, 8'h0A, 8'h08, 3'd3, "h_reraise");
      hstep(1'b0, 1'b1, 8'h02, 8'h02, 3'd1, "h_back");
      repeat (2) hstep(1'b0, 1'b0, 8'h00, 8'h02, 3'd1, "h_freeze");
      hstep(1'b0, 1'b1, 8'h00, 8'h00, 3'd0, "h_idle");
      hstep(1'b0, 1'b1, 8'h0A, 8'h08, 3'd3, "h_after_idle");

      // random sweep on N=2,3,5,16
      sw_chk = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      sw_rst = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         sw_req = (c % 3 == 0) ? $urandom() : ($urandom() | $urandom());
         sw_en  = ($urandom_range(0, 7) != 0);
         @(posedge clk); #1;
      end
      @(negedge clk); #1;
      sw_chk = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
